load_return_unit: RTL

- Memory-stage companion that consumes synchronous data-SRAM read data one cycle after a load is issued.
- Tracks each outstanding load's width, byte offset, sign mode, destination register and PC.
- Aligns and extends the returned word, and holds it when writeback stalls, because SRAM read data is valid for exactly one cycle.
- Sits between the data-memory request logic and the writeback stage / register-file forwarding network.

---
 rtl/load_return_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/load_return_unit.sv
// Load return unit: aligns and extends the SRAM read word for an outstanding load.
// It holds the result in local registers while writeback is stalled.
`ifndef memWidth4
`define memWidth1 2'd0
`define memWidth2 2'd1
`define memWidth4 2'd2
`endif

module load_return_unit #(
  parameter int DEST_W = 5,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issueValid,
  output logic              issueReady,
  input  logic [1:0]        issueWidth,
  input  logic [1:0]        issueAddrLow,
  input  logic              issueSigned,
  input  logic [DEST_W-1:0] issueDest,
  input  logic [PC_W-1:0]   issuePC,
  input  logic [31:0]       data_sram_rdata,
  input  logic              wbStall,
  input  logic              flush,
  output logic              loadValid,
  output logic [31:0]       loadData,
  output logic [DEST_W-1:0] loadDest,
  output logic [PC_W-1:0]   loadPC,
  output logic              pending
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e            state_q;
  logic [1:0]        width_q;
  logic [1:0]        addr_q;
  logic              signed_q;
  logic [DEST_W-1:0] dest_q;
  logic [PC_W-1:0]   pc_q;
  logic [31:0]       hold_data_q;
  logic [DEST_W-1:0] hold_dest_q;
  logic [PC_W-1:0]   hold_pc_q;

  logic [31:0]       extracted_d;
  logic              accept_d;

  function automatic logic [31:0] extract(input logic [1:0] w, input logic [1:0] a,
                                          input logic s, input logic [31:0] rd);
    logic [15:0] half;
    logic [7:0]  byte_v;
    logic [31:0] r;
    half   = a[1] ? rd[31:16] : rd[15:0];
    byte_v = 8'h00;
    r      = rd;
    case (a)
      2'd0:    byte_v = rd[7:0];
      2'd1:    byte_v = rd[15:8];
      2'd2:    byte_v = rd[23:16];
      2'd3:    byte_v = rd[31:24];
      default: byte_v = rd[7:0];
    endcase
    case (w)
      `memWidth2: r = {{16{s & half[15]}}, half};
      `memWidth1: r = {{24{s & byte_v[7]}}, byte_v};
      default:    r = rd;
    endcase
    return r;
  endfunction

  // Handshake, alignment and output selection; WAIT forwards the live SRAM word.
  always_comb begin
    issueReady  = !flush && ((state_q == S_IDLE) || ((state_q == S_WAIT) && !wbStall));
    accept_d    = issueValid && issueReady;
    extracted_d = extract(width_q, addr_q, signed_q, data_sram_rdata);
    loadValid   = (state_q != S_IDLE);
    pending     = (state_q != S_IDLE);
    if (state_q == S_WAIT) begin
      loadData = extracted_d;
      loadDest = dest_q;
      loadPC   = pc_q;
    end else begin
      loadData = hold_data_q;
      loadDest = hold_dest_q;
      loadPC   = hold_pc_q;
    end
  end

  // State machine plus capture of issued fields and held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      width_q     <= 2'd0;
      addr_q      <= 2'd0;
      signed_q    <= 1'b0;
      dest_q      <= '0;
      pc_q        <= '0;
      hold_data_q <= 32'd0;
      hold_dest_q <= '0;
      hold_pc_q   <= '0;
    end else begin
      if (accept_d) begin
        width_q  <= issueWidth;
        addr_q   <= issueAddrLow;
        signed_q <= issueSigned;
        dest_q   <= issueDest;
        pc_q     <= issuePC;
      end
      // Capturing on every WAIT also keeps the last result visible while idle.
      if ((state_q == S_WAIT) && !flush) begin
        hold_data_q <= extracted_d;
        hold_dest_q <= dest_q;
        hold_pc_q   <= pc_q;
      end
      case (state_q)
        S_IDLE: state_q <= accept_d ? S_WAIT : S_IDLE;
        S_WAIT: begin
          if (flush)        state_q <= S_IDLE;
          else if (wbStall) state_q <= S_HOLD;
          else              state_q <= accept_d ? S_WAIT : S_IDLE;
        end
        S_HOLD:  state_q <= (flush || !wbStall) ? S_IDLE : S_HOLD;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
